// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes symbolic MIPS instructions and loads them into instruction memory at boot
module instr_encoder_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_clear;
    logic                w_accept;
    logic                w_ptr_max;
    logic [31:0]         w_word;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;

    assign in_ready   = (r_state == S_LOAD);
    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);
    assign cpu_hold   = (r_state != S_DONE);
    assign w_accept   = in_valid & in_ready;
    assign w_ptr_max  = &r_ptr;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign word_count = r_count;

    // Instruction encoder: rd is don't-care for I-type, imm is don't-care for R-type
    always_comb begin
        w_word = '0;
        case (in_kind)
            3'd0:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
            3'd1:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
            3'd2:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
            3'd3:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
            3'd4:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
            3'd5:    w_word = {6'b100011, in_rs, in_rt, in_imm};
            3'd6:    w_word = {6'b101011, in_rs, in_rt, in_imm};
            default: w_word = {6'b000100, in_rs, in_rt, in_imm};
        endcase
    end

    // Session state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is only honoured outside LOAD
    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_next = S_DONE;
                    end else if (w_ptr_max) begin
                        w_next = S_ERR;
                    end
                end
            end
            default: begin
                if (start) begin
                    w_next  = S_LOAD;
                    w_clear = 1'b1;
                end
            end
        endcase
    end

    // Write datapath: accepted word appears on the memory port one cycle later, pointer never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_accept;
            if (w_clear) begin
                r_ptr   <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                r_addr  <= r_ptr;
                r_wdata <= w_word;
                r_count <= r_count + (ADDR_W+1)'(1);
                if (!w_ptr_max) begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                end
            end
        end
    end

endmodule
